// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory arbiter
// Purpose: FSM state encoding, port-select encoding and width defaults used
//          by mem_arbiter, mem_arb_pick and the testbench.
// Ports:   none (package)
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 16;
  localparam int MEM_ARB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection for the memory arbiter
// Purpose: chooses which port is granted when the arbiter samples requests.
//          Default build: fixed priority, data port wins a tie.
//          MEM_ARB_RR_EN defined: a tie goes to the port not granted last.
// Ports:   i_req      in  fetch request
//          d_req      in  data request
//          last_grant in  port granted on the previous access
//          sel        out selected port (only meaningful when a request is present)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  sel_e last_grant,
  output sel_e sel
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    sel = SEL_D;
    if (i_req && !d_req) begin
      sel = SEL_I;
    end else if (i_req && d_req) begin
      sel = (last_grant == SEL_D) ? SEL_I : SEL_D;
    end
  end
`else
  // Fixed priority never looks at the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    sel = SEL_D;
    if (i_req && !d_req) begin
      sel = SEL_I;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter for a synchronous memory
// Purpose: grants one of the fetch or data ports, drives a registered access
//          to a synchronous memory and returns read data plus a one-cycle ack.
//          Each access runs IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE.
//          Optional macro MEM_ARB_RR_EN selects round-robin tie breaking.
// Ports:   clk, rst_n                  clock, async active-low reset
//          i_req, i_addr               fetch read request
//          i_ack, i_rdata              fetch completion pulse, registered data
//          d_req, d_we, d_addr, d_wdata data-port request
//          d_ack, d_rdata              data completion pulse, registered data
//          mem_addr, mem_data, mem_write registered memory controls
//          mem_out                     memory read data (valid in CAPTURE)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int DATA_W = MEM_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out
);

  state_e state, state_nxt;
  sel_e   pick_sel;
  sel_e   win_sel;
  sel_e   last_grant;
  logic   win_we;
  logic   grant;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .sel        (pick_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The winner and its request are latched at grant time so that requester
  // input changes later in the access have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_write  <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      win_sel    <= SEL_I;
      win_we     <= 1'b0;
      last_grant <= SEL_D;
    end else begin
      // mem_write is only ever set on the grant edge, so it lasts exactly ACCESS
      mem_write <= 1'b0;
      i_ack     <= (state == CAPTURE) && (win_sel == SEL_I);
      d_ack     <= (state == CAPTURE) && (win_sel == SEL_D);

      if (grant) begin
        win_sel    <= pick_sel;
        last_grant <= pick_sel;
        if (pick_sel == SEL_D) begin
          mem_addr  <= d_addr;
          mem_data  <= d_wdata;
          mem_write <= d_we;
          win_we    <= d_we;
        end else begin
          mem_addr  <= i_addr;
          mem_write <= 1'b0;
          win_we    <= 1'b0;
        end
      end

      if ((state == CAPTURE) && !win_we) begin
        if (win_sel == SEL_I) begin
          i_rdata <= mem_out;
        end else begin
          d_rdata <= mem_out;
        end
      end
    end
  end

endmodule
